// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: fetch and pipeline-control unit for the 5-stage core.
// Owns the PC and the IF/ID register. Generates the load-use stall and the
// branch flush, selects forwarding sources for both EX operands, detects
// program completion after a pipeline-drain window, and keeps saturating
// cycle/stall/flush counters.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   inst_in                        instruction memory data at pc
//   id_rs1/2, id_rs1/2_used        sources of the ID instruction
//   ex_rd, ex_rd_we, ex_is_load    destination info of the EX instruction
//   ex_rs1, ex_rs2                 sources of the EX instruction
//   fwd_we, fwd_addr               write enable / destination per later stage
//   br_taken, br_target            resolved branch redirect
//   pc, if_id_pc/inst/valid        fetch address and IF/ID register
//   stall, flush                   combinational pipeline controls
//   fwd_sel_1, fwd_sel_2           0 = register file, k = forwarding stage k
//   done                           sticky completion flag
//   cyc_cnt, stall_cnt, flush_cnt  saturating performance counters
module pipeline_ctrl #(
  parameter int PC_W      = 6,
  parameter int INST_W    = 32,
  parameter int RA_W      = 5,
  parameter int PROG_LEN  = 32,
  parameter int FWD_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [INST_W-1:0]              inst_in,
  input  logic [RA_W-1:0]                id_rs1,
  input  logic [RA_W-1:0]                id_rs2,
  input  logic                           id_rs1_used,
  input  logic                           id_rs2_used,
  input  logic [RA_W-1:0]                ex_rd,
  input  logic                           ex_rd_we,
  input  logic                           ex_is_load,
  input  logic [RA_W-1:0]                ex_rs1,
  input  logic [RA_W-1:0]                ex_rs2,
  input  logic [FWD_DEPTH-1:0]           fwd_we,
  input  logic [FWD_DEPTH*RA_W-1:0]      fwd_addr,
  input  logic                           br_taken,
  input  logic [PC_W-1:0]                br_target,
  output logic [PC_W-1:0]                pc,
  output logic [PC_W-1:0]                if_id_pc,
  output logic [INST_W-1:0]              if_id_inst,
  output logic                           if_id_valid,
  output logic                           stall,
  output logic                           flush,
  output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_sel_1,
  output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_sel_2,
  output logic                           done,
  output logic [CNT_W-1:0]               cyc_cnt,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               flush_cnt
);

  localparam int SEL_W   = $clog2(FWD_DEPTH + 1);
  localparam int DRAIN_W = $clog2(FWD_DEPTH + 2);
  // Bubble edges needed before the last instruction has left every stage.
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(FWD_DEPTH + 1);
  localparam logic [PC_W-1:0]    PC_END     = PC_W'(PROG_LEN);

  logic [DRAIN_W-1:0] drain_cnt;
  logic               load_use;

  assign load_use = if_id_valid & ex_is_load & ex_rd_we & (ex_rd != '0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) |
                     (id_rs2_used & (id_rs2 == ex_rd)));

  // A taken branch kills the ID instruction anyway, so it suppresses stall.
  assign flush = br_taken & ~done;
  assign stall = ~done & ~br_taken & load_use;

  // Scan from the farthest stage down so the nearest match is the one kept.
  always_comb begin
    fwd_sel_1 = '0;
    fwd_sel_2 = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (fwd_we[k-1] && (ex_rs1 != '0) && (fwd_addr[(k-1)*RA_W +: RA_W] == ex_rs1))
        fwd_sel_1 = SEL_W'(k);
      if (fwd_we[k-1] && (ex_rs2 != '0) && (fwd_addr[(k-1)*RA_W +: RA_W] == ex_rs2))
        fwd_sel_2 = SEL_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      if_id_pc    <= '0;
      if_id_inst  <= '0;
      if_id_valid <= 1'b0;
      done        <= 1'b0;
      drain_cnt   <= '0;
      cyc_cnt     <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (!done) begin
      if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
      if (br_taken) begin
        pc          <= br_target;
        if_id_pc    <= '0;
        if_id_inst  <= '0;
        if_id_valid <= 1'b0;
        drain_cnt   <= '0;
        if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end else if (stall) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end else if (pc < PC_END) begin
        if_id_pc    <= pc;
        if_id_inst  <= inst_in;
        if_id_valid <= 1'b1;
        pc          <= pc + 1'b1;
      end else begin
        // Draining: feed bubbles until the window has elapsed.
        if_id_pc    <= '0;
        if_id_inst  <= '0;
        if_id_valid <= 1'b0;
        if (drain_cnt == DRAIN_LAST) done <= 1'b1;
        else                         drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  localparam int PC_W = 6, INST_W = 32, RA_W = 5, PROG_LEN = 32, FWD_DEPTH = 3;

  logic clk, rst_n;
  logic [INST_W-1:0] inst_in;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2;
  logic id_rs1_used, id_rs2_used, ex_rd_we, ex_is_load, br_taken;
  logic [FWD_DEPTH-1:0] fwd_we;
  logic [FWD_DEPTH*RA_W-1:0] fwd_addr;
  logic [PC_W-1:0] br_target;

  logic [PC_W-1:0] pc, if_id_pc;
  logic [INST_W-1:0] if_id_inst;
  logic if_id_valid, stall, flush, done;
  logic [1:0] fwd_sel_1, fwd_sel_2;
  logic [15:0] cyc_cnt, stall_cnt, flush_cnt;

  // Narrow-counter copy used for the saturation checks.
  logic [PC_W-1:0] s_pc, s_if_id_pc;
  logic [INST_W-1:0] s_if_id_inst;
  logic s_if_id_valid, s_stall, s_flush, s_done;
  logic [1:0] s_fwd_sel_1, s_fwd_sel_2;
  logic [2:0] s_cyc_cnt, s_stall_cnt, s_flush_cnt;

  logic [PC_W-1:0] pc_snap;

  assign inst_in = 32'hC0DE0000 | 32'(pc);

  pipeline_ctrl #(.PC_W(PC_W), .INST_W(INST_W), .RA_W(RA_W), .PROG_LEN(PROG_LEN),
                  .FWD_DEPTH(FWD_DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .inst_in(inst_in),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .fwd_we(fwd_we), .fwd_addr(fwd_addr),
    .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
    .stall(stall), .flush(flush), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
    .done(done), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_ctrl #(.PC_W(PC_W), .INST_W(INST_W), .RA_W(RA_W), .PROG_LEN(PROG_LEN),
                  .FWD_DEPTH(FWD_DEPTH), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .inst_in(inst_in),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .fwd_we(fwd_we), .fwd_addr(fwd_addr),
    .br_taken(br_taken), .br_target(br_target),
    .pc(s_pc), .if_id_pc(s_if_id_pc), .if_id_inst(s_if_id_inst), .if_id_valid(s_if_id_valid),
    .stall(s_stall), .flush(s_flush), .fwd_sel_1(s_fwd_sel_1), .fwd_sel_2(s_fwd_sel_2),
    .done(s_done), .cyc_cnt(s_cyc_cnt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {S_PC, S_IFPC, S_INST, S_VALID, S_STALL, S_FLUSH, S_F1, S_F2,
                    S_DONE, S_CYC, S_SCNT, S_FCNT, S_SAT_SCNT, S_SAT_CYC} sig_e;
  typedef struct {
    string       name;
    sig_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event sample_ev;

  function automatic logic [31:0] actual(sig_e s);
    case (s)
      S_PC:       return 32'(pc);
      S_IFPC:     return 32'(if_id_pc);
      S_INST:     return if_id_inst;
      S_VALID:    return 32'(if_id_valid);
      S_STALL:    return 32'(stall);
      S_FLUSH:    return 32'(flush);
      S_F1:       return 32'(fwd_sel_1);
      S_F2:       return 32'(fwd_sel_2);
      S_DONE:     return 32'(done);
      S_CYC:      return 32'(cyc_cnt);
      S_SCNT:     return 32'(stall_cnt);
      S_FCNT:     return 32'(flush_cnt);
      S_SAT_SCNT: return 32'(s_stall_cnt);
      S_SAT_CYC:  return 32'(s_cyc_cnt);
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: whenever the stimulus announces a sample point, drain the queue.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = actual(e.sel);
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", e.name, act, act, e.exp, e.exp);
        end
      end
    end
  end

  task automatic exp_(string n, sig_e s, logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = s; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    -> sample_ev;
    #1;
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = '0; ex_rd_we = 0; ex_is_load = 0; br_taken = 0; br_target = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_hazards();
    ex_rs1 = '0; ex_rs2 = '0; fwd_we = '0; fwd_addr = '0;
    #2;
    exp_("rst_pc", S_PC, 0); exp_("rst_valid", S_VALID, 0); exp_("rst_done", S_DONE, 0);
    exp_("rst_cyc", S_CYC, 0); exp_("rst_inst", S_INST, 0);
    sample();
    rst_n = 1'b1;

    // Three clean fetches.
    step(3);
    exp_("fetch_pc", S_PC, 3); exp_("fetch_ifpc", S_IFPC, 2);
    exp_("fetch_inst", S_INST, 32'hC0DE0002); exp_("fetch_valid", S_VALID, 1);
    exp_("fetch_cyc", S_CYC, 3); exp_("fetch_stall", S_STALL, 0); exp_("fetch_flush", S_FLUSH, 0);
    sample();

    // Load-use on rs2.
    ex_is_load = 1; ex_rd = 4; ex_rd_we = 1; id_rs2 = 4; id_rs2_used = 1;
    #1;
    exp_("lu_stall", S_STALL, 1); exp_("lu_flush", S_FLUSH, 0);
    sample();
    step();
    exp_("lu_pc_hold", S_PC, 3); exp_("lu_ifpc_hold", S_IFPC, 2);
    exp_("lu_scnt", S_SCNT, 1); exp_("lu_cyc", S_CYC, 4);
    sample();
    ex_rd = 0;
    #1;
    exp_("lu_rd0_stall", S_STALL, 0);
    sample();

    // Branch coincident with a load-use: flush wins, stall suppressed.
    ex_rd = 4; br_taken = 1; br_target = 7;
    #1;
    exp_("br_flush", S_FLUSH, 1); exp_("br_stall", S_STALL, 0);
    sample();
    step();
    exp_("br_pc", S_PC, 7); exp_("br_valid", S_VALID, 0); exp_("br_inst", S_INST, 0);
    exp_("br_fcnt", S_FCNT, 1); exp_("br_scnt", S_SCNT, 1); exp_("br_cyc", S_CYC, 5);
    sample();
    clear_hazards();

    // Forwarding selection (combinational).
    ex_rs1 = 3; ex_rs2 = 5; fwd_we = 3'b110;
    fwd_addr = {5'd5, 5'd3, 5'd3};
    #1;
    exp_("fwd1_stage2", S_F1, 2); exp_("fwd2_stage3", S_F2, 3);
    sample();
    fwd_we = 3'b111; fwd_addr = {5'd3, 5'd3, 5'd3};
    #1;
    exp_("fwd1_nearest", S_F1, 1); exp_("fwd2_nomatch", S_F2, 0);
    sample();
    ex_rs1 = 0; fwd_addr = '0;
    #1;
    exp_("fwd1_x0", S_F1, 0);
    sample();
    ex_rs1 = '0; ex_rs2 = '0; fwd_we = '0;

    // Run to end of program.
    step(25);
    exp_("end_pc", S_PC, 32); exp_("end_ifpc", S_IFPC, 31); exp_("end_valid", S_VALID, 1);
    exp_("end_cyc", S_CYC, 30);
    sample();
    step(2);
    exp_("drain2_valid", S_VALID, 0); exp_("drain2_done", S_DONE, 0); exp_("drain2_pc", S_PC, 32);
    sample();

    // Branch on the 3rd bubble edge restarts fetch and the drain window.
    br_taken = 1; br_target = 30;
    step();
    br_taken = 0;
    exp_("drain_br_pc", S_PC, 30); exp_("drain_br_done", S_DONE, 0); exp_("drain_br_fcnt", S_FCNT, 2);
    sample();
    step(2);
    exp_("refetch_pc", S_PC, 32); exp_("refetch_ifpc", S_IFPC, 31); exp_("refetch_valid", S_VALID, 1);
    sample();
    step(4);
    exp_("bubble4_done", S_DONE, 0); exp_("bubble4_valid", S_VALID, 0);
    sample();
    step();
    exp_("bubble5_done", S_DONE, 1); exp_("done_cyc", S_CYC, 40);
    exp_("done_pc", S_PC, 32); exp_("done_scnt", S_SCNT, 1);
    sample();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_done: done=%0b, expected 1", done);
    end

    // After done: everything frozen, controls masked.
    br_taken = 1; br_target = 3; ex_is_load = 1; ex_rd = 4; ex_rd_we = 1; id_rs2 = 4; id_rs2_used = 1;
    #1;
    exp_("frozen_flush", S_FLUSH, 0); exp_("frozen_stall", S_STALL, 0);
    sample();
    step(2);
    exp_("frozen_pc", S_PC, 32); exp_("frozen_cyc", S_CYC, 40);
    exp_("frozen_fcnt", S_FCNT, 2); exp_("frozen_done", S_DONE, 1);
    sample();
    clear_hazards();

    // Restart, then a long stall to saturate the narrow counters.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step(2);
    ex_is_load = 1; ex_rd = 9; ex_rd_we = 1; id_rs1 = 9; id_rs1_used = 1;
    #1;
    exp_("lu_rs1_stall", S_STALL, 1);
    sample();
    pc_snap = pc;
    step(10);
    exp_("long_stall_pc", S_PC, 2); exp_("long_stall_scnt", S_SCNT, 10); exp_("long_stall_cyc", S_CYC, 12);
    exp_("sat_scnt", S_SAT_SCNT, 7); exp_("sat_cyc", S_SAT_CYC, 7);
    sample();
    n_checks++;
    if (pc !== pc_snap) begin
      n_fail++;
      $display("FAIL direct_stall_hold: pc=%0d, expected %0d", pc, pc_snap);
    end
    n_checks++;
    if (s_stall_cnt !== 3'd7) begin
      n_fail++;
      $display("FAIL direct_sat: s_stall_cnt=%0d, expected 7", s_stall_cnt);
    end

    // Asynchronous reset in the middle of a stall cycle.
    #2;
    rst_n = 1'b0;
    #1;
    exp_("arst_pc", S_PC, 0); exp_("arst_ifpc", S_IFPC, 0); exp_("arst_inst", S_INST, 0);
    exp_("arst_valid", S_VALID, 0); exp_("arst_stall", S_STALL, 0); exp_("arst_cyc", S_CYC, 0);
    exp_("arst_scnt", S_SCNT, 0); exp_("arst_fcnt", S_FCNT, 0); exp_("arst_sat_scnt", S_SAT_SCNT, 0);
    sample();

    #5;
    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL check_count: only %0d checks evaluated", n_checks);
    end
    if (n_fail != 0)
      $display("FAIL summary: %0d failures", n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
